// File: rtl/snn_pkg.sv
// snn_pkg: widths, FSM state type and LFSR constants shared by the SNN pipeline stages.
package snn_pkg;
    localparam int DATA_W = 16;
    localparam int ADDR_W = 12;
    localparam int DIM_W  = 6;
    localparam logic [15:0] LFSR_MASK    = 16'hB400;
    localparam logic [15:0] DEFAULT_SEED = 16'hACE1;
    typedef enum logic [2:0] {IDLE, READ, WAIT, WRITE, DONE} state_t;
    function automatic logic [15:0] lfsr_next(input logic [15:0] v);
        return (v >> 1) ^ (v[0] ? LFSR_MASK : 16'h0000);
    endfunction
endpackage

// File: rtl/lfsr16.sv
// lfsr16: 16-bit right-shift Galois LFSR; a zero load value is replaced by DEFAULT_SEED so it never locks up.
module lfsr16
    import snn_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        load,
    input  logic [15:0] load_value,
    input  logic        step,
    output logic [15:0] value
);
    logic [15:0] value_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) value_q <= DEFAULT_SEED;
        else if (load) value_q <= (load_value == 16'h0000) ? DEFAULT_SEED : load_value;
        else if (step) value_q <= lfsr_next(value_q);
    end
    assign value = value_q;
endmodule

// File: rtl/spike_encoder.sv
// spike_encoder: rate-codes a grayscale frame into a 0/1 spike frame, 3 cycles per pixel.
// Define SPIKE_ENC_COUNT_EN to add the spike_count output.
module spike_encoder
    import snn_pkg::*;
#(
    parameter int PIX_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    output logic              done,
    input  logic [15:0]       seed,
    input  logic [DIM_W-1:0]  row_size,
    input  logic [DIM_W-1:0]  col_size,
    input  logic [ADDR_W-1:0] src_start_address,
    output logic [ADDR_W-1:0] src_address,
    input  logic [DATA_W-1:0] src_readdata,
    input  logic [ADDR_W-1:0] dest_start_address,
    output logic [ADDR_W-1:0] dest_address,
    output logic [DATA_W-1:0] dest_writedata,
    output logic              dest_write_en
`ifdef SPIKE_ENC_COUNT_EN
   ,output logic [ADDR_W-1:0] spike_count
`endif
);
    state_t              state_q;
    logic [ADDR_W-1:0]   n_q, idx_q, src_base_q, dest_base_q, src_addr_q, dest_addr_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                we_q, done_q;
    logic [ADDR_W-1:0]   n_d;
    logic [15:0]         lfsr_val;
    logic                spike_d;
    logic                unused_hi;

    assign n_d       = ADDR_W'(row_size) * ADDR_W'(col_size);
    assign spike_d   = src_readdata[PIX_W-1:0] > lfsr_val[PIX_W-1:0];
    assign unused_hi = ^{src_readdata[DATA_W-1:PIX_W], lfsr_val[15:PIX_W]};

    // The LFSR sample used for a pixel's compare is consumed on the WAIT->WRITE edge.
    lfsr16 u_lfsr (
        .clk        (clk),
        .reset      (reset),
        .load       (state_q == IDLE && start),
        .load_value (seed),
        .step       (state_q == WAIT),
        .value      (lfsr_val)
    );

`ifdef SPIKE_ENC_COUNT_EN
    logic [ADDR_W-1:0] cnt_q;
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) cnt_q <= '0;
        else if (state_q == IDLE && start) cnt_q <= '0;
        else if (state_q == WAIT) cnt_q <= cnt_q + ADDR_W'(spike_d);
    end
    assign spike_count = cnt_q;
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q     <= IDLE;
            n_q         <= '0;
            idx_q       <= '0;
            src_base_q  <= '0;
            dest_base_q <= '0;
            src_addr_q  <= '0;
            dest_addr_q <= '0;
            wdata_q     <= '0;
            we_q        <= 1'b0;
            done_q      <= 1'b0;
        end else begin
            we_q <= 1'b0;
            case (state_q)
                IDLE: if (start) begin
                    n_q         <= n_d;
                    idx_q       <= '0;
                    src_base_q  <= src_start_address;
                    dest_base_q <= dest_start_address;
                    src_addr_q  <= src_start_address;
                    state_q     <= (n_d == '0) ? DONE : READ;
                    done_q      <= (n_d == '0);
                end
                READ: state_q <= WAIT;
                WAIT: begin
                    // Read data is valid during WAIT, so the write beat is registered here.
                    dest_addr_q <= dest_base_q + idx_q;
                    wdata_q     <= {{(DATA_W-1){1'b0}}, spike_d};
                    we_q        <= 1'b1;
                    state_q     <= WRITE;
                end
                WRITE: begin
                    idx_q      <= idx_q + 1'b1;
                    src_addr_q <= src_base_q + idx_q + 1'b1;
                    state_q    <= (idx_q == n_q - 1'b1) ? DONE : READ;
                    done_q     <= (idx_q == n_q - 1'b1);
                end
                DONE: if (!start) begin
                    state_q <= IDLE;
                    done_q  <= 1'b0;
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign done           = done_q;
    assign src_address    = src_addr_q;
    assign dest_address   = dest_addr_q;
    assign dest_writedata = wdata_q;
    assign dest_write_en  = we_q;
endmodule

// File: tb/tb_spike_encoder.sv
// tb_spike_encoder: directed frames with random pixels, checked against an arithmetic Bernoulli-coding model.
module tb_spike_encoder;
    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [15:0] seed = 16'h0;
    logic [5:0]  row_size = '0, col_size = '0;
    logic [11:0] sbase = '0, dbase = '0;
    logic        done, dest_write_en;
    logic [11:0] src_address, dest_address;
    logic [15:0] src_readdata, dest_writedata;
`ifdef SPIKE_ENC_COUNT_EN
    logic [11:0] spike_count;
`endif

    spike_encoder dut (
        .clk                (clk),
        .reset              (reset),
        .start              (start),
        .done               (done),
        .seed               (seed),
        .row_size           (row_size),
        .col_size           (col_size),
        .src_start_address  (sbase),
        .src_address        (src_address),
        .src_readdata       (src_readdata),
        .dest_start_address (dbase),
        .dest_address       (dest_address),
        .dest_writedata     (dest_writedata),
        .dest_write_en      (dest_write_en)
`ifdef SPIKE_ENC_COUNT_EN
       ,.spike_count        (spike_count)
`endif
    );

    always #5 clk = ~clk;

    logic [15:0] pix_mem [4096];
    always @(posedge clk) src_readdata <= pix_mem[src_address];

    logic        log_clr = 1'b0;
    logic [11:0] log_addr [4096];
    logic [15:0] log_data [4096];
    int          wr_cnt = 0;
    always @(posedge clk) begin
        if (log_clr) wr_cnt <= 0;
        else if (dest_write_en && wr_cnt < 4096) begin
            log_addr[wr_cnt] <= dest_address;
            log_data[wr_cnt] <= dest_writedata;
            wr_cnt <= wr_cnt + 1;
        end
    end

    int   errors = 0, checks = 0;
    int   pv [64];
    logic exp_spk [64];
    int   exp_cnt;
    logic [15:0] saved [64];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    // mode 0: zeros, 1: i*30, 2: random 16-bit words, 3: all 255
    task automatic fill(input int n, input logic [11:0] base, input int mode);
        for (int i = 0; i < n; i++) begin
            logic [11:0] a;
            pv[i] = (mode == 0) ? 0 : (mode == 1) ? i * 30 : (mode == 2) ? int'($urandom_range(0, 65535)) : 255;
            a = base + 12'(i);
            pix_mem[a] = 16'(pv[i]);
        end
    endtask

    task automatic model(input int n, input logic [15:0] sd);
        int l;
        l = (sd == 0) ? 'hACE1 : int'(sd);
        exp_cnt = 0;
        for (int i = 0; i < n; i++) begin
            exp_spk[i] = (pv[i] % 256) > (l % 256);
            exp_cnt += int'(exp_spk[i]);
            l = (l % 2 == 1) ? ((l / 2) ^ 'hB400) : (l / 2);
        end
    endtask

    task automatic begin_frame(input int r, input int c, input logic [15:0] sd, input logic [11:0] sb, input logic [11:0] db);
        @(negedge clk);
        log_clr = 1'b1; row_size = 6'(r); col_size = 6'(c); seed = sd; sbase = sb; dbase = db; start = 1'b1;
        @(posedge clk);
        #1 log_clr = 1'b0;
    endtask

    task automatic run_frame(input string tag, input int r, input int c, input logic [15:0] sd, input logic [11:0] sb, input logic [11:0] db);
        int n, lat;
        n = r * c;
        model(n, sd);
        begin_frame(r, c, sd, sb, db);
        start = 1'b0;
        lat = 1;
        while (done !== 1'b1 && lat <= 400) begin
            @(posedge clk);
            #1 lat++;
        end
        check({tag, "_latency"}, lat, (n == 0) ? 1 : 3 * n + 1);
        check({tag, "_writes"}, wr_cnt, n);
        for (int i = 0; i < n; i++) begin
            logic [11:0] ea;
            ea = db + 12'(i);
            check($sformatf("%s_addr%0d", tag, i), log_addr[i], ea);
            check($sformatf("%s_spike%0d", tag, i), log_data[i], 32'(exp_spk[i]));
        end
`ifdef SPIKE_ENC_COUNT_EN
        check({tag, "_count"}, spike_count, exp_cnt);
`endif
        @(posedge clk);
        #1 check({tag, "_idle"}, done, 0);
    endtask

    initial begin
        #3 reset = 1'b0;
        #1;
        check("rst_done", done, 0);
        check("rst_we", dest_write_en, 0);
        check("rst_src", src_address, 0);
        check("rst_dest", dest_address, 0);
        check("rst_wdata", dest_writedata, 0);
        repeat (2) @(negedge clk);
        reset = 1'b1;

        fill(4, 12'd0, 0);
        run_frame("zero2x2", 2, 2, 16'hACE1, 12'd0, 12'd100);

        fill(9, 12'd20, 1);
        run_frame("ramp3x3", 3, 3, 16'hACE1, 12'd20, 12'd200);

        fill(6, 12'd500, 2);
        run_frame("seedA", 2, 3, 16'hACE1, 12'd500, 12'd600);
        for (int i = 0; i < 6; i++) saved[i] = log_data[i];
        run_frame("seed0", 2, 3, 16'h0000, 12'd500, 12'd700);
        for (int i = 0; i < 6; i++) check($sformatf("seed_eq%0d", i), log_data[i], saved[i]);

        fill(16, 12'd300, 2);
        begin_frame(4, 4, 16'h1234, 12'd300, 12'd400);
        start = 1'b0;
        repeat ($urandom_range(3, 40)) @(posedge clk);
        #2 reset = 1'b0;
        #1;
        check("abort_done", done, 0);
        check("abort_we", dest_write_en, 0);
        check("abort_src", src_address, 0);
        check("abort_dest", dest_address, 0);
        check("abort_wdata", dest_writedata, 0);
        @(negedge clk);
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1 check("abort_nodone", done, 0);
        run_frame("rerun4x4", 4, 4, 16'h1234, 12'd300, 12'd400);

        begin_frame(0, 5, 16'hACE1, 12'd0, 12'd900);
        check("empty_done", done, 1);
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1 check($sformatf("empty_hold%0d", i), done, 1);
        end
        @(negedge clk) start = 1'b0;
        @(posedge clk);
        #1 check("empty_release", done, 0);
        check("empty_writes", wr_cnt, 0);

        fill(4, 12'd800, 3);
        run_frame("wrap", 2, 2, 16'($urandom_range(1, 65535)), 12'd800, 12'd4094);

        fill(5, 12'd1000, 2);
        run_frame("rand1x5", 1, 5, 16'($urandom_range(0, 65535)), 12'd1000, 12'd1100);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/spike_encoder.md
Name: spike_encoder

Overview:
Upstream stage of conv_unit. Converts a grayscale input frame in a pixel RAM into a binary rate-coded (Bernoulli) spike frame.
- For each pixel: compare intensity against a 16-bit LFSR sample; write 16'd1 (spike) or 16'd0 into the RAM that conv_unit later reads as src1.
- Uses the same start/done, start-address and row/col-size interface style as conv_unit, max_pooling and matrix_fc.

Parameters:
DATA_W, 16, RAM data width
ADDR_W, 12, RAM address width
DIM_W, 6, row/col size width
PIX_W, 8, pixel bits used (src_readdata[PIX_W-1:0]); upper bits ignored
DEFAULT_SEED, 16'hACE1, LFSR value loaded when seed input is 0

Ports:
clk  input  1  system clock, rising edge
reset  input  1  asynchronous active-low reset
start  input  1  level request; sampled in IDLE
done  output  1  frame complete; held high in DONE
seed  input  16  LFSR seed, captured on accepted start
row_size  input  DIM_W  frame rows
col_size  input  DIM_W  frame columns
src_start_address  input  ADDR_W  pixel RAM base
src_address  output  ADDR_W  pixel RAM read address
src_readdata  input  DATA_W  pixel RAM data, 1-cycle synchronous read latency
dest_start_address  input  ADDR_W  spike RAM base
dest_address  output  ADDR_W  spike RAM address
dest_writedata  output  DATA_W  spike value, 16'd0 or 16'd1
dest_write_en  output  1  spike RAM write strobe

Behaviour:
- Reset (reset=0, asynchronous):
  - state=IDLE; done=0, dest_write_en=0.
  - src_address, dest_address and dest_writedata are 0.
  - Pixel index = 0; LFSR = DEFAULT_SEED.
- Reset mid-frame: abort immediately. Partial spike frame is left in RAM. No done.
- FSM states: IDLE, READ, WAIT, WRITE, DONE.
- IDLE:
  - start=1 captures N = row_size*col_size (12-bit; max 3969, no overflow).
  - Captures seed; seed=0 is replaced by DEFAULT_SEED.
  - Index cleared.
  - If N=0, go to DONE with no writes; otherwise go to READ.
- READ: src_address = src_start_address + index (mod 2^ADDR_W). Go to WAIT.
- WAIT: RAM latency cycle. Go to WRITE.
- WRITE:
  - Spike = (src_readdata[PIX_W-1:0] > lfsr[PIX_W-1:0]), unsigned.
  - dest_address = dest_start_address + index (mod 2^ADDR_W).
  - dest_writedata = {15'd0, spike}; dest_write_en=1 for exactly this cycle.
  - LFSR advances one step; index increments.
  - If index was N-1, go to DONE; else go to READ.
- DONE:
  - done=1; dest_write_en=0.
  - Remain while start=1; go to IDLE when start=0 (done drops the same edge).
- LFSR: 16-bit Galois, right shift, feedback mask 16'hB400 (x^16+x^14+x^13+x^11+1). Never zero.
- Per-pixel cost is 3 cycles. done rises 3N+1 cycles after start is accepted (N>0), or 1 cycle after (N=0).
- Consequences of the compare rule:
  - Pixel 0 never spikes.
  - Pixel 255 spikes unless the LFSR byte is 255.
- Timing of inputs:
  - start deasserted mid-frame is ignored; the frame completes.
  - row_size, col_size, start addresses and seed are only sampled at accept.
- src and dest ranges may overlap. Each pixel is read before its own write, so in-place encoding is legal when the bases are equal.
- Outputs are registered; no combinational path from input to output.

Optional Feature:
Macro SPIKE_ENC_COUNT_EN.
- Defined:
  - Adds output spike_count (ADDR_W bits), cleared on accept.
  - Increments on each WRITE with spike=1; stable and valid while done=1.
  - Reset value 0.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Shared package snn_pkg holds:
  - DATA_W, ADDR_W, DIM_W;
  - the state enum typedef (IDLE/READ/WAIT/WRITE/DONE);
  - LFSR_MASK = 16'hB400 and DEFAULT_SEED.
- One natural sub-module: lfsr16. Inputs clk, reset, load, load_value, step; output value. It carries the zero-seed substitution.

Test Plan:
- Reset: reset=0 at arbitrary cycle during a 4x4 frame -> all outputs 0 immediately. Next start=1 re-runs the full frame from index 0.
- 2x2 frame, all pixels 0, src base 0, dest base 100 -> writes of 16'd0 at addresses 100..103. done high at cycle 13 after accept.
- 3x3 frame, pixels 0..8 scaled by 30, seed 16'hACE1 -> dest values match a bit-exact LFSR model, one compare per pixel.
- Seed=0 vs seed=16'hACE1 on same 2x3 frame -> identical spike frames.
- row_size=0, col_size=5 -> no dest_write_en; done=1 one cycle after accept. Hold start high 10 cycles -> done stays high; start low -> IDLE.
- dest_start_address=12'd4094, 2x2 frame -> writes at 4094, 4095, 0, 1. With SPIKE_ENC_COUNT_EN and pixels 255, spike_count equals the number of LFSR bytes not equal to 255.
